// File: rtl/pre_if_prefetch_queue.sv
// pre_if_prefetch_queue: pre-IF fetch stage. Keeps up to DEPTH fetches outstanding on the
// inst_sram req/addr_ok/data_ok bus, buffers in-order responses in a circular queue and
// hands them to IF through a valid/allowin handshake. Flushes and redirects empty the queue
// and count the responses still in flight so they can be discarded when they arrive.
// Optional feature macro: PFS_PERF_CNT_EN (issued-fetch and dropped-response counters).
module pre_if_prefetch_queue #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         fs_allowin,
   output logic         pfs_to_fs_valid,
   output logic [101:0] pfs_to_fs_bus,
   output logic         inst_sram_req,
   output logic [31:0]  inst_sram_addr,
   input  logic         inst_sram_addr_ok,
   input  logic [31:0]  inst_sram_rdata,
   input  logic         inst_sram_data_ok,
   input  logic         tlb_refill,
   input  logic         tlb_invalid,
   input  logic         br_redirect,
   input  logic [31:0]  br_target,
   input  logic         do_flush,
   input  logic [31:0]  flush_pc,
   output logic [31:0]  perf_issue_cnt,
   output logic [31:0]  perf_drop_cnt
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [CntW-1:0] cnt_t;

   localparam cnt_t DepthCnt = cnt_t'(DEPTH);

   // Control state
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        halt_q, halt_d;
   ptr_t        head_q, head_d;
   ptr_t        fill_q, fill_d;
   ptr_t        tail_q, tail_d;
   cnt_t        count_q, count_d;
   cnt_t        unfilled_q, unfilled_d;
   cnt_t        drop_cnt_q, drop_cnt_d;

   // Queue storage
   logic [DEPTH-1:0] ent_filled_q;
   logic [DEPTH-1:0] ent_ex_q;
   logic [4:0]       ent_excode_q [DEPTH];
   logic [31:0]      ent_pc_q     [DEPTH];
   logic [31:0]      ent_inst_q   [DEPTH];

   logic restart;
   logic misaligned;
   logic fault;
   logic can_alloc;
   logic fault_alloc;
   logic issue;
   logic push;
   logic pop;
   logic resp_drop;
   logic resp_fill;

   // Issue, fault-allocation, pop and response decisions for this cycle
   always_comb begin
      restart         = do_flush | br_redirect;
      misaligned      = (fetch_pc_q[1:0] != 2'b00);
      fault           = misaligned | tlb_refill | tlb_invalid;
      // A full queue suppresses both the bus request and the fault check
      can_alloc       = !reset && !halt_q && (count_q < DepthCnt) && !restart;
      inst_sram_req   = can_alloc && !fault;
      fault_alloc     = can_alloc && fault;
      issue           = inst_sram_req && inst_sram_addr_ok;
      push            = issue | fault_alloc;
      pfs_to_fs_valid = !reset && ent_filled_q[head_q] && (count_q != '0) && !restart;
      pop             = pfs_to_fs_valid && fs_allowin;
      resp_drop       = inst_sram_data_ok && (drop_cnt_q != '0);
      resp_fill       = inst_sram_data_ok && (drop_cnt_q == '0) && !restart;
   end

   assign inst_sram_addr = fetch_pc_q;

   // Next-state for pointers, occupancy, drop count, halt and fetch PC
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      halt_d     = halt_q;
      head_d     = head_q;
      fill_d     = fill_q;
      tail_d     = tail_q;
      count_d    = count_q;
      unfilled_d = unfilled_q;
      drop_cnt_d = drop_cnt_q;
      if (restart) begin
         fetch_pc_d = do_flush ? flush_pc : br_target;
         halt_d     = 1'b0;
         head_d     = '0;
         fill_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         unfilled_d = '0;
         // Every unfilled entry still owes a response; one arriving now is already consumed
         drop_cnt_d = drop_cnt_q + unfilled_q - cnt_t'(inst_sram_data_ok);
      end else begin
         if (resp_drop) begin
            drop_cnt_d = drop_cnt_q - cnt_t'(1);
         end
         if (pop) begin
            head_d = head_q + ptr_t'(1);
         end
         if (push) begin
            tail_d = tail_q + ptr_t'(1);
         end
         if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (fault_alloc) begin
            halt_d = 1'b1;
         end
         count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
         unfilled_d = unfilled_q + cnt_t'(issue) - cnt_t'(resp_fill);
         // With nothing awaiting data, park the fill pointer at the tail so it skips
         // pre-filled fault entries
         if (unfilled_d == '0) begin
            fill_d = tail_d;
         end else if (resp_fill) begin
            fill_d = fill_q + ptr_t'(1);
         end
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         halt_q     <= 1'b0;
         head_q     <= '0;
         fill_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         unfilled_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         halt_q     <= halt_d;
         head_q     <= head_d;
         fill_q     <= fill_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         unfilled_q <= unfilled_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Queue storage: responses land in the fill entry, new fetches/faults at the tail
   always_ff @(posedge clk) begin
      if (reset) begin
         ent_filled_q <= '0;
         ent_ex_q     <= '0;
      end else begin
         if (resp_fill) begin
            ent_inst_q[fill_q]   <= inst_sram_rdata;
            ent_filled_q[fill_q] <= 1'b1;
         end
         if (push) begin
            ent_filled_q[tail_q] <= fault_alloc;
            ent_ex_q[tail_q]     <= fault_alloc;
            ent_excode_q[tail_q] <= misaligned ? 5'h04 : 5'h02;
            ent_pc_q[tail_q]     <= fetch_pc_q;
            if (fault_alloc) begin
               ent_inst_q[tail_q] <= 32'h0;
            end
         end
      end
   end

   // Head entry toward IF; badvaddr and excode only carry meaning on exception entries
   always_comb begin
      pfs_to_fs_bus = '0;
      if (pfs_to_fs_valid) begin
         pfs_to_fs_bus[31:0]  = ent_pc_q[head_q];
         pfs_to_fs_bus[63:32] = ent_inst_q[head_q];
         if (ent_ex_q[head_q]) begin
            pfs_to_fs_bus[95:64]  = ent_pc_q[head_q];
            pfs_to_fs_bus[100:96] = ent_excode_q[head_q];
            pfs_to_fs_bus[101]    = 1'b1;
         end
      end
   end

`ifdef PFS_PERF_CNT_EN
   logic [31:0] perf_issue_q;
   logic [31:0] perf_drop_q;
   logic        drop_evt;

   assign drop_evt = inst_sram_data_ok && (restart || (drop_cnt_q != '0));

   // Free-running event counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issue_q <= 32'h0;
         perf_drop_q  <= 32'h0;
      end else begin
         if (issue) begin
            perf_issue_q <= perf_issue_q + 32'd1;
         end
         if (drop_evt) begin
            perf_drop_q <= perf_drop_q + 32'd1;
         end
      end
   end

   assign perf_issue_cnt = perf_issue_q;
   assign perf_drop_cnt  = perf_drop_q;
`else
   assign perf_issue_cnt = 32'h0;
   assign perf_drop_cnt  = 32'h0;
`endif

`ifndef SYNTHESIS
   // Late responses owed can never exceed the queue depth
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (drop_cnt_q <= DepthCnt)
         else $error("pre_if_prefetch_queue: drop_cnt %0d exceeds DEPTH", drop_cnt_q);
      end
   end
`endif

endmodule

// File: tb/tb_pre_if_prefetch_queue.sv
// tb_pre_if_prefetch_queue: directed scenarios plus randomized traffic against a
// queue-level reference model of the pre-IF prefetch stage and a simple in-order bridge.
module tb_pre_if_prefetch_queue;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'hbfc00000;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         fs_allowin = 1'b0;
   logic         pfs_to_fs_valid;
   logic [101:0] pfs_to_fs_bus;
   logic         inst_sram_req;
   logic [31:0]  inst_sram_addr;
   logic         inst_sram_addr_ok = 1'b0;
   logic [31:0]  inst_sram_rdata = 32'h0;
   logic         inst_sram_data_ok = 1'b0;
   logic         tlb_refill = 1'b0;
   logic         tlb_invalid = 1'b0;
   logic         br_redirect = 1'b0;
   logic [31:0]  br_target = 32'h0;
   logic         do_flush = 1'b0;
   logic [31:0]  flush_pc = 32'h0;
   logic [31:0]  perf_issue_cnt;
   logic [31:0]  perf_drop_cnt;

   always #5 clk = ~clk;

   pre_if_prefetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .fs_allowin        (fs_allowin),
      .pfs_to_fs_valid   (pfs_to_fs_valid),
      .pfs_to_fs_bus     (pfs_to_fs_bus),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .inst_sram_data_ok (inst_sram_data_ok),
      .tlb_refill        (tlb_refill),
      .tlb_invalid       (tlb_invalid),
      .br_redirect       (br_redirect),
      .br_target         (br_target),
      .do_flush          (do_flush),
      .flush_pc          (flush_pc),
      .perf_issue_cnt    (perf_issue_cnt),
      .perf_drop_cnt     (perf_drop_cnt)
   );

   typedef struct {
      logic        filled;
      logic        ex;
      logic [4:0]  excode;
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } pend_t;

   // Reference model state
   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_halt;
   int          m_drop;
   logic [31:0] m_issue;
   logic [31:0] m_dropped;

   // Bridge model: accepted fetches awaiting their in-order response
   pend_t pend[$];
   int    lat_max;
   int    cyc;

   int n_cmp;
   int n_bad;
   int n_acc;
   logic [101:0] dq[$];
   int           dq_cyc[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic model_init();
      mq.delete();
      pend.delete();
      m_pc      = RESET_PC;
      m_halt    = 1'b0;
      m_drop    = 0;
      m_issue   = 32'h0;
      m_dropped = 32'h0;
   endtask

   task automatic apply_reset();
      reset             = 1'b1;
      fs_allowin        = 1'b0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      tlb_refill        = 1'b0;
      tlb_invalid       = 1'b0;
      br_redirect       = 1'b0;
      do_flush          = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_init();
      dq.delete();
      dq_cyc.delete();
      n_acc   = 0;
      lat_max = 0;
   endtask

   // One clock: drive at negedge, compare against the model, advance model and bridge
   task automatic cycle(input bit aok, input bit allow, input bit dok_en, input bit fl,
                        input logic [31:0] fpc, input bit br, input logic [31:0] tgt,
                        input bit refill, input bit inval);
      bit           dok, m_restart, m_fault, m_req, falloc, m_valid, acc, found;
      logic [101:0] m_bus;
      logic [31:0]  rdat, cur_pc, e_issue, e_drop;
      int           unf;
      dok  = dok_en && (pend.size() > 0) && (pend[0].ready <= cyc);
      rdat = dok ? mem_word(pend[0].addr) : $urandom;
      inst_sram_addr_ok = aok;
      fs_allowin        = allow;
      do_flush          = fl;
      flush_pc          = fpc;
      br_redirect       = br;
      br_target         = tgt;
      tlb_refill        = refill;
      tlb_invalid       = inval;
      inst_sram_data_ok = dok;
      inst_sram_rdata   = rdat;
      #1;
      cur_pc    = m_pc;
      m_restart = fl || br;
      m_fault   = (m_pc[1:0] != 2'b00) || refill || inval;
      m_req     = !m_halt && (mq.size() < DEPTH) && !m_restart && !m_fault;
      falloc    = !m_halt && (mq.size() < DEPTH) && !m_restart && m_fault;
      m_valid   = (mq.size() > 0) && mq[0].filled && !m_restart;
      m_bus     = '0;
      if (m_valid) begin
         m_bus = {mq[0].ex, mq[0].excode, (mq[0].ex ? mq[0].pc : 32'h0), mq[0].inst, mq[0].pc};
      end
`ifdef PFS_PERF_CNT_EN
      e_issue = m_issue;
      e_drop  = m_dropped;
`else
      e_issue = 32'h0;
      e_drop  = 32'h0;
`endif
      n_cmp++;
      if (inst_sram_req !== m_req) begin
         n_bad++;
         $display("FAIL req cyc=%0d got=%b exp=%b", cyc, inst_sram_req, m_req);
      end
      if (m_req) begin
         n_cmp++;
         if (inst_sram_addr !== m_pc) begin
            n_bad++;
            $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, inst_sram_addr, m_pc);
         end
      end
      n_cmp++;
      if (pfs_to_fs_valid !== m_valid) begin
         n_bad++;
         $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, pfs_to_fs_valid, m_valid);
      end
      n_cmp++;
      if (pfs_to_fs_bus !== m_bus) begin
         n_bad++;
         $display("FAIL bus cyc=%0d got=%h exp=%h", cyc, pfs_to_fs_bus, m_bus);
      end
      n_cmp++;
      if (perf_issue_cnt !== e_issue) begin
         n_bad++;
         $display("FAIL perf_issue cyc=%0d got=%0d exp=%0d", cyc, perf_issue_cnt, e_issue);
      end
      n_cmp++;
      if (perf_drop_cnt !== e_drop) begin
         n_bad++;
         $display("FAIL perf_drop cyc=%0d got=%0d exp=%0d", cyc, perf_drop_cnt, e_drop);
      end
      if (pfs_to_fs_valid === 1'b1 && allow) begin
         dq.push_back(pfs_to_fs_bus);
         dq_cyc.push_back(cyc);
      end
      if (inst_sram_req === 1'b1 && aok) n_acc++;

      acc = m_req && aok;
      if (m_restart) begin
         unf = 0;
         foreach (mq[k]) if (!mq[k].filled) unf++;
         m_drop = m_drop + unf - int'(dok);
         if (dok) m_dropped = m_dropped + 32'd1;
         mq.delete();
         m_halt = 1'b0;
         m_pc   = fl ? fpc : tgt;
      end else begin
         if (dok) begin
            if (m_drop > 0) begin
               m_drop--;
               m_dropped = m_dropped + 32'd1;
            end else begin
               found = 1'b0;
               for (int k = 0; k < mq.size(); k++) begin
                  if (!found && !mq[k].filled) begin
                     mq[k].filled = 1'b1;
                     mq[k].inst   = rdat;
                     found        = 1'b1;
                  end
               end
            end
         end
         if (m_valid && allow) void'(mq.pop_front());
         if (acc) begin
            mq.push_back('{1'b0, 1'b0, 5'h00, cur_pc, 32'h0});
            m_pc    = cur_pc + 32'd4;
            m_issue = m_issue + 32'd1;
         end
         if (falloc) begin
            mq.push_back('{1'b1, 1'b1, ((cur_pc[1:0] != 2'b00) ? 5'h04 : 5'h02), cur_pc, 32'h0});
            m_halt = 1'b1;
         end
      end
      if (dok) void'(pend.pop_front());
      if (acc) pend.push_back('{cur_pc, cyc + 1 + int'($urandom_range(0, lat_max))});
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      reset             = 1'b1;
      inst_sram_addr_ok = 1'b1;
      fs_allowin        = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (inst_sram_req !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_req got=%b exp=0", inst_sram_req);
      end
      n_cmp++;
      if (pfs_to_fs_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_valid got=%b exp=0", pfs_to_fs_valid);
      end
      n_cmp++;
      if (pfs_to_fs_bus !== 102'h0) begin
         n_bad++;
         $display("FAIL reset_bus got=%h exp=0", pfs_to_fs_bus);
      end
      n_cmp++;
      if (perf_issue_cnt !== 32'h0 || perf_drop_cnt !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_perf got=%h/%h exp=0/0", perf_issue_cnt, perf_drop_cnt);
      end
      @(negedge clk);
      reset             = 1'b0;
      inst_sram_addr_ok = 1'b0;
      fs_allowin        = 1'b0;
      model_init();
      #1;
      n_cmp++;
      if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
         n_bad++;
         $display("FAIL reset_first_fetch got=%b/%h exp=1/%h", inst_sram_req, inst_sram_addr,
                  RESET_PC);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int c0;
      apply_reset();
      c0 = cyc;
      repeat (10) cycle(1, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0);
      n_cmp++;
      if (dq.size() < 3) begin
         n_bad++;
         $display("FAIL b2b_count got=%0d exp>=3", dq.size());
      end else begin
         n_cmp++;
         if (dq[0][31:0] !== 32'hbfc00000 || dq[1][31:0] !== 32'hbfc00004 ||
             dq[2][31:0] !== 32'hbfc00008) begin
            n_bad++;
            $display("FAIL b2b_pcs got=%h,%h,%h exp=bfc00000,bfc00004,bfc00008",
                     dq[0][31:0], dq[1][31:0], dq[2][31:0]);
         end
         n_cmp++;
         if (dq_cyc[0] != c0 + 2 || dq_cyc[1] != c0 + 3) begin
            n_bad++;
            $display("FAIL b2b_timing got=%0d,%0d exp=%0d,%0d", dq_cyc[0] - c0, dq_cyc[1] - c0,
                     2, 3);
         end
         n_cmp++;
         if (dq[0][63:32] !== mem_word(32'hbfc00000)) begin
            n_bad++;
            $display("FAIL b2b_inst got=%h exp=%h", dq[0][63:32], mem_word(32'hbfc00000));
         end
      end
   endtask

   task automatic test_full_backpressure();
      apply_reset();
      repeat (6) cycle(1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
      #1;
      n_cmp++;
      if (n_acc != 2 || inst_sram_req !== 1'b0) begin
         n_bad++;
         $display("FAIL full_stall got=%0d/%b exp=2/0", n_acc, inst_sram_req);
      end
      n_cmp++;
      if (pfs_to_fs_valid !== 1'b1 || pfs_to_fs_bus[31:0] !== 32'hbfc00000) begin
         n_bad++;
         $display("FAIL full_head got=%b/%h exp=1/bfc00000", pfs_to_fs_valid,
                  pfs_to_fs_bus[31:0]);
      end
      @(negedge clk);
      repeat (2) cycle(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0);
      n_cmp++;
      if (dq.size() != 2) begin
         n_bad++;
         $display("FAIL full_drain got=%0d exp=2", dq.size());
      end else if (dq[0][31:0] !== 32'hbfc00000 || dq[1][31:0] !== 32'hbfc00004) begin
         n_bad++;
         $display("FAIL full_drain got=%h,%h exp=bfc00000,bfc00004", dq[0][31:0], dq[1][31:0]);
      end
      repeat (3) cycle(1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
      n_cmp++;
      if (n_acc != 4) begin
         n_bad++;
         $display("FAIL full_resume got=%0d exp=4", n_acc);
      end
   endtask

   task automatic test_flush_drop();
      apply_reset();
      repeat (2) cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
      cycle(1, 0, 0, 1, 32'hbfc00380, 0, 32'h0, 0, 0);
      repeat (12) cycle(1, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0);
      n_cmp++;
      if (dq.size() < 2) begin
         n_bad++;
         $display("FAIL flush_count got=%0d exp>=2", dq.size());
      end else if (dq[0][31:0] !== 32'hbfc00380 || dq[0][63:32] !== mem_word(32'hbfc00380) ||
                   dq[1][31:0] !== 32'hbfc00384) begin
         n_bad++;
         $display("FAIL flush_first got=%h/%h,%h exp=bfc00380/%h,bfc00384", dq[0][31:0],
                  dq[0][63:32], dq[1][31:0], mem_word(32'hbfc00380));
      end
`ifdef PFS_PERF_CNT_EN
      n_cmp++;
      if (perf_drop_cnt !== 32'd2) begin
         n_bad++;
         $display("FAIL flush_perf_drop got=%0d exp=2", perf_drop_cnt);
      end
`endif
   endtask

   task automatic test_redirect_same_cycle();
      apply_reset();
      cycle(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
      cycle(0, 0, 1, 0, 32'h0, 1, 32'h80001000, 0, 0);
      repeat (8) cycle(1, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0);
      n_cmp++;
      if (dq.size() < 1) begin
         n_bad++;
         $display("FAIL redir_count got=0 exp>=1");
      end else if (dq[0][31:0] !== 32'h80001000 || dq[0][63:32] !== mem_word(32'h80001000)) begin
         n_bad++;
         $display("FAIL redir_first got=%h/%h exp=80001000/%h", dq[0][31:0], dq[0][63:32],
                  mem_word(32'h80001000));
      end
   endtask

   task automatic test_misaligned_fault();
      apply_reset();
      cycle(1, 1, 1, 1, 32'hbfc00002, 0, 32'h0, 0, 0);
      n_acc = 0;
      repeat (6) cycle(1, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0);
      #1;
      n_cmp++;
      if (n_acc != 0 || inst_sram_req !== 1'b0) begin
         n_bad++;
         $display("FAIL adel_halt got=%0d/%b exp=0/0", n_acc, inst_sram_req);
      end
      n_cmp++;
      if (dq.size() != 1) begin
         n_bad++;
         $display("FAIL adel_count got=%0d exp=1", dq.size());
      end else if (dq[0][101] !== 1'b1 || dq[0][100:96] !== 5'h04 ||
                   dq[0][95:64] !== 32'hbfc00002 || dq[0][31:0] !== 32'hbfc00002) begin
         n_bad++;
         $display("FAIL adel_entry got=%h exp=ex=1 code=04 bva=bfc00002 pc=bfc00002", dq[0]);
      end
      @(negedge clk);
      cycle(1, 1, 1, 1, 32'hbfc00100, 0, 32'h0, 0, 0);
      repeat (4) cycle(1, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0);
      n_cmp++;
      if (dq.size() < 2 || dq[dq.size() - 1][101] !== 1'b0) begin
         n_bad++;
         $display("FAIL adel_recover got=%0d entries exp>=2 normal", dq.size());
      end else if (dq[1][31:0] !== 32'hbfc00100) begin
         n_bad++;
         $display("FAIL adel_recover got=%h exp=bfc00100", dq[1][31:0]);
      end
   endtask

   task automatic test_tlb_fault();
      apply_reset();
      cycle(1, 1, 1, 1, 32'h00400000, 0, 32'h0, 0, 0);
      n_acc = 0;
      cycle(1, 1, 1, 0, 32'h0, 0, 32'h0, 1, 0);
      repeat (4) cycle(1, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0);
      n_cmp++;
      if (n_acc != 0) begin
         n_bad++;
         $display("FAIL tlbl_noreq got=%0d exp=0", n_acc);
      end
      n_cmp++;
      if (dq.size() != 1) begin
         n_bad++;
         $display("FAIL tlbl_count got=%0d exp=1", dq.size());
      end else if (dq[0][101] !== 1'b1 || dq[0][100:96] !== 5'h02 ||
                   dq[0][95:64] !== 32'h00400000 || dq[0][31:0] !== 32'h00400000) begin
         n_bad++;
         $display("FAIL tlbl_entry got=%h exp=ex=1 code=02 bva=00400000", dq[0]);
      end
`ifdef PFS_PERF_CNT_EN
      n_cmp++;
      if (perf_issue_cnt !== 32'd0) begin
         n_bad++;
         $display("FAIL tlbl_perf_issue got=%0d exp=0", perf_issue_cnt);
      end
`endif
   endtask

   task automatic test_random();
      int          unf;
      bit          can_rs, fl, br, aok, allow, dok_en, refill, inval;
      logic [31:0] fpc, tgt;
      apply_reset();
      lat_max = 2;
      for (int i = 0; i < 3000; i++) begin
         unf = 0;
         foreach (mq[k]) if (!mq[k].filled) unf++;
         can_rs = (m_drop + unf) <= DEPTH;
         fl     = can_rs && ($urandom_range(0, 24) == 0);
         br     = can_rs && ($urandom_range(0, 24) == 0);
         aok    = $urandom_range(0, 3) != 0;
         allow  = $urandom_range(0, 3) != 0;
         dok_en = $urandom_range(0, 3) != 0;
         refill = $urandom_range(0, 39) == 0;
         inval  = $urandom_range(0, 39) == 0;
         fpc    = $urandom;
         tgt    = $urandom;
         if ($urandom_range(0, 3) != 0) fpc[1:0] = 2'b00;
         tgt[1:0] = 2'b00;
         cycle(aok, allow, dok_en, fl, fpc, br, tgt, refill, inval);
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      n_acc   = 0;
      cyc     = 0;
      lat_max = 0;
      model_init();
      test_reset();
      test_back_to_back();
      test_full_backpressure();
      test_flush_drop();
      test_redirect_same_cycle();
      test_misaligned_fault();
      test_tlb_fault();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
